// File: rtl/jt51_noise_sync.sv
// Recovers lock onto the jt51 17-bit XNOR noise generator by predicting
// each received bit from the last 17 and tracking misprediction statistics.
module jt51_noise_sync #(
  parameter int LOCK_CNT = 8,
  parameter int MISS_MAX = 2
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic       base,
  input  logic       din,
  input  logic       clr_err,
  output logic       locked,
  output logic       mism,
  output logic [7:0] err_cnt,
  output logic       stuck,
  output logic       pred
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_CNT);
  localparam logic [2:0] MISS_LIM = 3'(MISS_MAX);

  logic [1:0]  state, state_nx;
  logic [16:0] h;
  logic [4:0]  fill, fill_nx;
  logic [3:0]  good, good_nx;
  logic [2:0]  miss, miss_nx;
  logic        sample, hit, inc;

  assign sample = cen & base;
  // Generator recurrence: s[n+17] = ~(s[n] ^ s[n+3])
  assign pred   = ~(h[16] ^ h[13]);
  assign hit    = (din == pred);
  assign stuck  = (fill == 5'd17) & (h == 17'h1FFFF);
  assign locked = (state == LOCKED);
  assign inc    = sample & (state == LOCKED) & ~hit;

  always_comb begin
    state_nx = state;
    fill_nx  = fill;
    good_nx  = good;
    miss_nx  = miss;
    if (sample) begin
      case (state)
        HUNT: begin
          fill_nx = fill + 5'd1;
          if (fill == 5'd16) begin
            state_nx = VERIFY;
            good_nx  = 4'd0;
          end
        end
        VERIFY: begin
          if (hit) begin
            good_nx = good + 4'd1;
            if (good + 4'd1 == LOCK_LIM) begin
              state_nx = LOCKED;
              miss_nx  = 3'd0;
            end
          end else begin
            good_nx = 4'd0;
          end
        end
        LOCKED: begin
          if (hit) begin
            miss_nx = 3'd0;
          end else begin
            miss_nx = miss + 3'd1;
            if (miss + 3'd1 == MISS_LIM) begin
              state_nx = HUNT;
              fill_nx  = 5'd0;
              good_nx  = 4'd0;
            end
          end
        end
        default: begin
          state_nx = HUNT;
          fill_nx  = 5'd0;
          good_nx  = 4'd0;
          miss_nx  = 3'd0;
        end
      endcase
    end
  end

  // mism is recomputed every clock so it can only be high right after a LOCKED miss
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HUNT;
      h       <= 17'd0;
      fill    <= 5'd0;
      good    <= 4'd0;
      miss    <= 3'd0;
      err_cnt <= 8'd0;
      mism    <= 1'b0;
    end else begin
      mism <= inc;
      if (cen) begin
        state <= state_nx;
        fill  <= fill_nx;
        good  <= good_nx;
        miss  <= miss_nx;
        if (base) h <= {h[15:0], din};
        if (clr_err) err_cnt <= {7'd0, inc};
        else if (inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_jt51_noise_sync.sv
// Directed scenarios for jt51_noise_sync; a per-clock reference model feeds a
// scoreboard queue drained by a negedge monitor, plus hand-computed checkpoints.
module tb_jt51_noise_sync;

  localparam int LOCK_CNT = 8;
  localparam int MISS_MAX = 2;

  logic       rst, clk, cen, base, din, clr_err;
  logic       locked, mism, stuck, pred;
  logic [7:0] err_cnt;

  jt51_noise_sync #(.LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX)) dut (
    .rst(rst), .clk(clk), .cen(cen), .base(base), .din(din), .clr_err(clr_err),
    .locked(locked), .mism(mism), .err_cnt(err_cnt), .stuck(stuck), .pred(pred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       locked;
    logic       mism;
    logic [7:0] err;
    logic       stuck;
    logic       pred;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state
  int          m_state, m_fill, m_good, m_miss, m_err;
  logic [16:0] m_h;
  logic        m_mism;
  logic [16:0] gen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_fill = 0; m_good = 0; m_miss = 0; m_err = 0;
    m_h = 17'd0; m_mism = 1'b0;
  endtask

  function automatic logic model_pred();
    return ~(m_h[16] ^ m_h[13]);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.locked = (m_state == 2);
    e.mism   = m_mism;
    e.err    = m_err[7:0];
    e.stuck  = (m_fill == 17) && (m_h == 17'h1FFFF);
    e.pred   = model_pred();
    return e;
  endfunction

  task automatic model_clk(input logic c, input logic b, input logic d, input logic clr);
    logic p;
    logic inc;
    p = model_pred();
    inc = 1'b0;
    m_mism = 1'b0;
    if (!c) return;
    if (b) begin
      if (m_state == 0) begin
        m_fill++;
        if (m_fill == 17) begin m_state = 1; m_good = 0; end
      end else if (m_state == 1) begin
        if (d == p) begin
          m_good++;
          if (m_good == LOCK_CNT) begin m_state = 2; m_miss = 0; end
        end else m_good = 0;
      end else begin
        if (d == p) m_miss = 0;
        else begin
          inc = 1'b1;
          m_miss++;
          if (m_miss == MISS_MAX) begin m_state = 0; m_fill = 0; m_good = 0; end
        end
      end
      m_h = {m_h[15:0], d};
    end
    if (clr) m_err = inc ? 1 : 0;
    else if (inc && m_err < 255) m_err++;
    m_mism = inc;
  endtask

  task automatic step(input logic c, input logic b, input logic d, input logic clr);
    cen = c; base = b; din = d; clr_err = clr;
    @(posedge clk);
    if (rst) model_reset();
    else model_clk(c, b, d, clr);
    q.push_back(model_out());
    #1;
  endtask

  task automatic sample(input logic d);
    step(1'b1, 1'b1, d, 1'b0);
  endtask

  task automatic gen_next(output logic b);
    b = gen[16];
    gen = {gen[15:0], ~(gen[16] ^ gen[13])};
  endtask

  // sample with three idle cen cycles before it: base on every 4th cen
  task automatic gen_sample4();
    logic b;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    gen_next(b);
    sample(b);
  endtask

  // async reset landing mid-cycle with a live sample pending on the inputs
  task automatic pulse_reset();
    @(negedge clk);
    #1;
    cen = 1'b1; base = 1'b1; din = 1'b1; clr_err = 1'b1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_mism", mism, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_stuck", stuck, 0);
    chk("rst_pred", pred, 1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
  endtask

  // monitor: one expected entry per clock, compared away from the active edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_locked", locked, e.locked);
      chk("sb_mism", mism, e.mism);
      chk("sb_err", err_cnt, e.err);
      chk("sb_stuck", stuck, e.stuck);
      chk("sb_pred", pred, e.pred);
    end
  end

  initial begin
    logic b;
    rst = 1'b1; cen = 1'b0; base = 1'b0; din = 1'b0; clr_err = 1'b0;
    model_reset();
    gen = 17'd14220;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("init_locked", locked, 0);
    chk("init_err", err_cnt, 0);
    chk("init_pred", pred, 1);

    // lock onto the generator: 17 fill + 8 matches
    for (int i = 1; i <= 24; i++) gen_sample4();
    chk("lock_pre25", locked, 0);
    gen_sample4();
    chk("lock_at25", locked, 1);
    chk("lock_err0", err_cnt, 0);

    // one inverted bit: miss now, then again at h[13] and h[16]
    gen_next(b);
    sample(~b);
    chk("inv_mism", mism, 1);
    chk("inv_err1", err_cnt, 1);
    chk("inv_locked", locked, 1);
    sample(b ^ b ^ gen[16]);
    gen_next(b);
    chk("inv_mism_clear", mism, 0);
    for (int i = 0; i < 19; i++) begin gen_next(b); sample(b); end
    chk("inv_err3", err_cnt, 3);
    chk("inv_still_locked", locked, 1);

    // two forced misses drop lock; relock after 25 clean samples
    sample(~model_pred());
    chk("force1_err", err_cnt, 4);
    chk("force1_locked", locked, 1);
    sample(~model_pred());
    chk("force2_err", err_cnt, 5);
    chk("force2_locked", locked, 0);
    for (int i = 1; i <= 24; i++) begin gen_next(b); sample(b); end
    chk("relock_pre25", locked, 0);
    gen_next(b);
    sample(b);
    chk("relock_at25", locked, 1);

    // freezes: base without cen, then cen without base
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'($urandom_range(1)), 1'b0);
    chk("freeze_err", err_cnt, 5);
    chk("freeze_locked", locked, 1);

    pulse_reset();
    chk("post_rst_locked", locked, 0);
    chk("post_rst_err", err_cnt, 0);

    // all-ones stream: stuck from sample 17, lock at 25
    for (int i = 1; i <= 16; i++) sample(1'b1);
    chk("ones_stuck16", stuck, 0);
    sample(1'b1);
    chk("ones_stuck17", stuck, 1);
    for (int i = 18; i <= 25; i++) sample(1'b1);
    chk("ones_locked", locked, 1);
    sample(1'b0);
    chk("ones_err1", err_cnt, 1);
    chk("ones_unstuck", stuck, 0);
    sample(1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr_with_miss", err_cnt, 1);
    chk("clr_locked", locked, 1);

    // all-zeros stream never locks
    pulse_reset();
    for (int i = 0; i < 60; i++) sample(1'b0);
    chk("zeros_locked", locked, 0);
    chk("zeros_stuck", stuck, 0);
    chk("zeros_err", err_cnt, 0);

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
